// File: rtl/tdc_therm_encoder.sv
// TDC thermometer encoder: bubble-corrects the delay-line snapshot, detects new hits
// on tap 0 and emits coarse/fine timestamps over a valid/ready interface.
module tdc_therm_encoder #(
  parameter int unsigned NTAPS    = 64,
  parameter int unsigned COARSE_W = 16,
  localparam int unsigned FINE_W  = $clog2(NTAPS + 1)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NTAPS-1:0]    therm,
  input  logic                ts_ready,
  output logic                ts_valid,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                coarse_wrap,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned DROP_W = 8;

  // Coarse counter and wrap pulse
  logic [COARSE_W-1:0] r_cnt;
  logic                r_wrap;

  // Stage 0: raw snapshot
  logic [NTAPS-1:0]    r_t0;
  logic [COARSE_W-1:0] r_c0;
  logic                r_t0_vld;

  // Stage 1: bubble-corrected line
  logic [NTAPS-1:0]    r_b;
  logic [COARSE_W-1:0] r_c1;
  logic                r_b_vld;
  logic                r_b0_prev;

  // Output register
  logic                r_valid;
  logic [COARSE_W-1:0] r_coarse;
  logic [FINE_W-1:0]   r_fine;
  logic [DROP_W-1:0]   r_drop;

  logic [NTAPS+1:0]    w_t0_pad;
  logic [NTAPS-1:0]    w_b_maj;
  logic [FINE_W-1:0]   w_popcnt;
  logic                w_evt;
  logic                w_valid_nxt;
  logic [COARSE_W-1:0] w_coarse_nxt;
  logic [FINE_W-1:0]   w_fine_nxt;
  logic [DROP_W-1:0]   w_drop_nxt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + COARSE_W'(1);
      r_wrap <= (r_cnt == {COARSE_W{1'b1}});
    end
  end

  // Edge taps replicate themselves so the majority reduces to the tap value
  assign w_t0_pad = {r_t0[NTAPS-1], r_t0, r_t0[0]};

  always_comb begin
    w_b_maj = '0;
    for (int i = 0; i < NTAPS; i++) begin
      w_b_maj[i] = (w_t0_pad[i]   & w_t0_pad[i+1]) |
                   (w_t0_pad[i+1] & w_t0_pad[i+2]) |
                   (w_t0_pad[i]   & w_t0_pad[i+2]);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_t0     <= '0;
      r_c0     <= '0;
      r_t0_vld <= 1'b0;
    end else begin
      r_t0     <= therm;
      r_c0     <= r_cnt;
      r_t0_vld <= 1'b1;
    end
  end

  // b0_prev holds 1 until real data reaches stage 1, so a line saturated at
  // reset release is not mistaken for a rising edge out of the flushed zeros.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_b       <= '0;
      r_c1      <= '0;
      r_b_vld   <= 1'b0;
      r_b0_prev <= 1'b1;
    end else begin
      r_b     <= w_b_maj;
      r_c1    <= r_c0;
      r_b_vld <= r_t0_vld;
      if (r_b_vld) begin
        r_b0_prev <= r_b[0];
      end
    end
  end

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < NTAPS; i++) begin
      w_popcnt = w_popcnt + FINE_W'(r_b[i]);
    end
  end

  assign w_evt = r_b_vld & r_b[0] & ~r_b0_prev;

  // Output register next state: load, drop on back-pressure, or retire on accept
  always_comb begin
    w_valid_nxt  = r_valid;
    w_coarse_nxt = r_coarse;
    w_fine_nxt   = r_fine;
    w_drop_nxt   = r_drop;
    if (w_evt) begin
      if (!r_valid || ts_ready) begin
        w_valid_nxt  = 1'b1;
        w_coarse_nxt = r_c1;
        w_fine_nxt   = w_popcnt;
      end else if (r_drop != {DROP_W{1'b1}}) begin
        w_drop_nxt = r_drop + DROP_W'(1);
      end
    end else if (r_valid && ts_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_valid  <= 1'b0;
      r_coarse <= '0;
      r_fine   <= '0;
      r_drop   <= '0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_coarse <= w_coarse_nxt;
      r_fine   <= w_fine_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  assign ts_valid    = r_valid;
  assign ts_coarse   = r_coarse;
  assign ts_fine     = r_fine;
  assign coarse_wrap = r_wrap;
  assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Directed bench for tdc_therm_encoder (NTAPS=64, COARSE_W=4) with immediate-assertion checks.
module tb_tdc_therm_encoder;

  localparam int unsigned NTAPS    = 64;
  localparam int unsigned COARSE_W = 4;
  localparam int unsigned FINE_W   = 7;

  logic                clk;
  logic                clr;
  logic [NTAPS-1:0]    therm;
  logic                ts_ready;
  logic                ts_valid;
  logic [COARSE_W-1:0] ts_coarse;
  logic [FINE_W-1:0]   ts_fine;
  logic                coarse_wrap;
  logic [7:0]          drop_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [COARSE_W-1:0] m_cnt;
  logic [COARSE_W-1:0] exp_c;
  logic [COARSE_W-1:0] exp_c1;

  tdc_therm_encoder #(.NTAPS(NTAPS), .COARSE_W(COARSE_W)) dut (
    .clk         (clk),
    .clr         (clr),
    .therm       (therm),
    .ts_ready    (ts_ready),
    .ts_valid    (ts_valid),
    .ts_coarse   (ts_coarse),
    .ts_fine     (ts_fine),
    .coarse_wrap (coarse_wrap),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference coarse counter
  always @(posedge clk) m_cnt <= clr ? '0 : m_cnt + 4'd1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; therm = '0; ts_ready = 1'b0;
    tick(2);
    chk("rst_valid", 64'(ts_valid), 64'd0);
    chk("rst_coarse", 64'(ts_coarse), 64'd0);
    chk("rst_fine", 64'(ts_fine), 64'd0);
    chk("rst_wrap", 64'(coarse_wrap), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    // Coarse wrap at 16 and 32 cycles after release
    clr = 1'b0;
    tick(15);
    chk("wrap_pre", 64'(coarse_wrap), 64'd0);
    tick(1);
    chk("wrap_16", 64'(coarse_wrap), 64'd1);
    tick(1);
    chk("wrap_17", 64'(coarse_wrap), 64'd0);
    tick(15);
    chk("wrap_32", 64'(coarse_wrap), 64'd1);
    chk("idle_valid", 64'(ts_valid), 64'd0);

    // Basic hit 0x1F
    tick(4);
    exp_c = m_cnt;
    therm = 64'h1F;
    tick(1);
    therm = '0;
    tick(1);
    chk("t1_lat2", 64'(ts_valid), 64'd0);
    tick(1);
    chk("t1_valid", 64'(ts_valid), 64'd1);
    chk("t1_fine", 64'(ts_fine), 64'd5);
    chk("t1_coarse", 64'(ts_coarse), 64'(exp_c));
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;
    chk("t1_accept", 64'(ts_valid), 64'd0);

    // Bubble 0xBF -> 7 taps
    exp_c = m_cnt;
    therm = 64'hBF;
    tick(1);
    therm = '0;
    tick(2);
    chk("bub_valid", 64'(ts_valid), 64'd1);
    chk("bub_fine", 64'(ts_fine), 64'd7);
    chk("bub_coarse", 64'(ts_coarse), 64'(exp_c));
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;

    // Saturated line -> 64
    therm = '1;
    tick(1);
    therm = '0;
    tick(2);
    chk("sat_valid", 64'(ts_valid), 64'd1);
    chk("sat_fine", 64'(ts_fine), 64'd64);
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;

    // Capture at cnt=15
    for (int i = 0; i < 16 && m_cnt != 4'd15; i++) tick(1);
    therm = 64'h1;
    tick(1);
    therm = '0;
    tick(2);
    chk("c15_coarse", 64'(ts_coarse), 64'd15);
    chk("c15_fine", 64'(ts_fine), 64'd1);
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;

    // Back-pressure: second hit dropped
    exp_c1 = m_cnt;
    therm = 64'h7;
    tick(1);
    therm = '0;
    tick(3);
    therm = 64'hF;
    tick(1);
    therm = '0;
    tick(2);
    chk("bp_valid", 64'(ts_valid), 64'd1);
    chk("bp_fine", 64'(ts_fine), 64'd3);
    chk("bp_coarse", 64'(ts_coarse), 64'(exp_c1));
    chk("bp_drop", 64'(drop_cnt), 64'd1);
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;
    chk("bp_accept", 64'(ts_valid), 64'd0);

    // Accept and new event in the same cycle
    therm = 64'h3;
    tick(1);
    therm = '0;
    tick(2);
    chk("sc_first", 64'(ts_fine), 64'd2);
    exp_c = m_cnt;
    therm = 64'h3F;
    tick(1);
    therm = '0;
    tick(1);
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;
    chk("sc_valid", 64'(ts_valid), 64'd1);
    chk("sc_fine", 64'(ts_fine), 64'd6);
    chk("sc_coarse", 64'(ts_coarse), 64'(exp_c));
    chk("sc_drop", 64'(drop_cnt), 64'd1);
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;

    // clr one cycle after capture flushes the hit
    therm = 64'h1F;
    tick(1);
    therm = '0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("cf_valid", 64'(ts_valid), 64'd0);
    chk("cf_coarse", 64'(ts_coarse), 64'd0);
    chk("cf_fine", 64'(ts_fine), 64'd0);
    chk("cf_drop", 64'(drop_cnt), 64'd0);
    chk("cf_wrap", 64'(coarse_wrap), 64'd0);
    tick(3);
    chk("cf_later", 64'(ts_valid), 64'd0);

    // Saturated through reset: no event until a zero is seen
    therm = '1;
    clr = 1'b1;
    tick(3);
    clr = 1'b0;
    tick(6);
    chk("hs_noevt", 64'(ts_valid), 64'd0);
    therm = '0;
    tick(2);
    exp_c = m_cnt;
    therm = 64'h3;
    tick(1);
    therm = '0;
    tick(2);
    chk("hs_valid", 64'(ts_valid), 64'd1);
    chk("hs_fine", 64'(ts_fine), 64'd2);
    chk("hs_coarse", 64'(ts_coarse), 64'(exp_c));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
